pc_seq: RTL and testbench
=========================

PC_SEQ -- requirements
Module: pc_seq

Interface
REQ-001 Parameter AW, default 16, program-counter and offset width in bits (4..32).
REQ-002 Parameter DEPTH, default 8, return-stack entries (1..64).
REQ-003 Parameter RST_VEC, default 0, AW-bit PC value loaded on reset.
REQ-004 Port clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port rst  input  1  reset, asynchronous, active-low (asserted at 0).
REQ-006 Port en  input  1  advance enable; 0 = stall, all state holds.
REQ-007 Port jmp  input  1  jump request from decode.
REQ-008 Port cmp  input  1  condition result; a jump is taken only when jmp and cmp are both 1.
REQ-009 Port abs_mode  input  1  jump/call target select: 0 = pc_out+rd, 1 = rd.
REQ-010 Port call  input  1  subroutine call (unconditional).
REQ-011 Port ret  input  1  subroutine return (unconditional).
REQ-012 Port rd  input  AW  jump/call offset (two's complement) or absolute target.
REQ-013 Port pc_out  output  AW  current PC, driven directly from a register.
REQ-014 Port sp  output  clog2(DEPTH+1)  number of valid return-stack entries.
REQ-015 Port full  output  1  sp == DEPTH.
REQ-016 Port empty  output  1  sp == 0.
REQ-017 Port fault  output  1  sticky fault indicator; 1 exactly when in FAULT state.

Function
REQ-018 Two states, RUN and FAULT; FAULT is left only by reset.
REQ-019 RUN with en=0: pc_out, sp, stack contents hold; all other inputs ignored.
REQ-020 RUN with en=1: one action per cycle, priority (call&&ret) > ret > call > taken jump > increment.
REQ-021 Target T = rd when abs_mode=1, else (pc_out + rd) mod 2^AW.
REQ-022 Increment: pc_out <= (pc_out + 1) mod 2^AW; 2^AW-1 wraps to 0 with no flag.
REQ-023 Taken jump (jmp&&cmp): pc_out <= T; jmp with cmp=0 increments.
REQ-024 Call, not full: push (pc_out+1) mod 2^AW into stack[sp], sp <= sp+1, pc_out <= T, in the same cycle.
REQ-025 Ret, not empty: pc_out <= stack[sp-1], sp <= sp-1.
REQ-026 Call while full (overflow), ret while empty (underflow), or call and ret together: next state FAULT; pc_out, sp, stack unchanged.
REQ-027 FAULT: pc_out, sp, stack frozen regardless of en, jmp, call, ret; fault=1.
REQ-028 jmp/cmp ignored in any cycle where call or ret is 1.
REQ-029 All outputs registered or decoded from registered state only; no combinational input-to-output path.
REQ-030 Latency: action issued at edge N is visible on pc_out after edge N; one PC update per enabled cycle.

Reset
REQ-031 rst=0 asynchronously forces: pc_out=RST_VEC, sp=0, empty=1, full=0, fault=0, state RUN.
REQ-032 Stack storage is not cleared by reset; entries at index >= sp are never observable.
REQ-033 Reset mid-call or mid-ret aborts the action; the first enabled edge after release increments from RST_VEC.
REQ-034 Reset release is sampled on clk; no state change on the release edge other than normal RUN behaviour.

Verification (AW=16, DEPTH=4, RST_VEC=0x0000)
REQ-035 Reset then 3 cycles en=1, no requests -> pc_out 0x0001, 0x0002, 0x0003; sp=0, empty=1.
REQ-036 pc_out=0x0010, jmp=1, cmp=1, abs_mode=0, rd=0xFFFC -> pc_out=0x000C; same with cmp=0 -> 0x0011; abs_mode=1, rd=0x1234, taken -> 0x1234.
REQ-037 pc_out=0x0020, call, abs_mode=1, rd=0x0100 -> pc_out=0x0100, sp=1; two increments then ret -> pc_out=0x0021, sp=0, empty=1.
REQ-038 Four nested calls -> sp=4, full=1; fifth call -> fault=1, pc_out and sp unchanged, held through 10 further enabled cycles; rst pulse low -> pc_out=0x0000, fault=0.
REQ-039 From reset, ret -> fault=1, pc_out=0x0000; separately, call and ret together -> fault=1, sp unchanged.
REQ-040 pc_out=0xFFFF, increment -> 0x0000, fault=0; en=0 for 5 cycles with call asserted -> pc_out and sp unchanged.

Source files
------------

// File: rtl/pc_seq_if.sv
// Control/status bundle between decode and the program-counter sequencer.
// master = decode side driving requests, slave = sequencer.
interface pc_seq_if #(
    parameter int AW    = 16,
    parameter int DEPTH = 8
);
    localparam int SPW = $clog2(DEPTH + 1);

    logic          en;
    logic          jmp;
    logic          cmp;
    logic          abs_mode;
    logic          call;
    logic          ret;
    logic [AW-1:0] rd;
    logic [AW-1:0] pc_out;
    logic [SPW-1:0] sp;
    logic          full;
    logic          empty;
    logic          fault;

    modport master (
        output en, jmp, cmp, abs_mode, call, ret, rd,
        input  pc_out, sp, full, empty, fault
    );

    modport slave (
        input  en, jmp, cmp, abs_mode, call, ret, rd,
        output pc_out, sp, full, empty, fault
    );
endinterface

// File: rtl/pc_seq.sv
// Program-counter sequencer: increment, jump, call/return with a
// bounded return stack; stack misuse parks the unit in a sticky FAULT.
module pc_seq #(
    parameter int            AW      = 16,
    parameter int            DEPTH   = 8,
    parameter logic [AW-1:0] RST_VEC = '0
) (
    input logic     clk,
    input logic     rst,
    pc_seq_if.slave bus
);
    localparam int SPW = $clog2(DEPTH + 1);
    localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } state_t;

    state_t         r_state;
    logic [AW-1:0]  r_pc;
    logic [SPW-1:0] r_sp;
    logic [AW-1:0]  r_stack [DEPTH];

    logic           w_full;
    logic           w_empty;
    logic           w_act;
    logic           w_bad;
    logic           w_push;
    logic           w_pop;
    logic           w_jump;
    logic           w_step;
    logic [AW-1:0]  w_target;
    logic [AW-1:0]  w_inc;
    logic [SPW-1:0] w_sp_dec;
    logic [IW-1:0]  w_wr_idx;
    logic [IW-1:0]  w_rd_idx;

    assign w_full   = (r_sp == SPW'(DEPTH));
    assign w_empty  = (r_sp == '0);
    assign w_act    = (r_state == RUN) && bus.en;
    assign w_inc    = r_pc + {{(AW-1){1'b0}}, 1'b1};
    assign w_target = bus.abs_mode ? bus.rd : r_pc + bus.rd;
    assign w_sp_dec = r_sp - {{(SPW-1){1'b0}}, 1'b1};

    // sp-1 never exceeds DEPTH-1, so the low bits are an exact index
    assign w_wr_idx = r_sp[IW-1:0];
    assign w_rd_idx = w_sp_dec[IW-1:0];

    assign w_bad  = w_act && ((bus.call && bus.ret) ||
                              (bus.call && w_full)  ||
                              (bus.ret  && w_empty));
    assign w_pop  = w_act && bus.ret && !bus.call && !w_empty;
    assign w_push = w_act && bus.call && !bus.ret && !w_full;
    assign w_jump = w_act && !bus.call && !bus.ret &&
                    bus.jmp && bus.cmp;
    assign w_step = w_act && !bus.call && !bus.ret && !w_jump;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= RUN;
            r_pc    <= RST_VEC;
            r_sp    <= '0;
        end else begin
            unique case (1'b1)
                w_bad: begin
                    r_state <= FAULT;
                end
                w_pop: begin
                    r_pc <= r_stack[w_rd_idx];
                    r_sp <= w_sp_dec;
                end
                w_push: begin
                    r_pc <= w_target;
                    r_sp <= r_sp + {{(SPW-1){1'b0}}, 1'b1};
                end
                w_jump: begin
                    r_pc <= w_target;
                end
                w_step: begin
                    r_pc <= w_inc;
                end
                default: begin
                end
            endcase
        end
    end

    // Storage is deliberately unreset; entries at or above sp are dead
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_stack[w_wr_idx] <= w_inc;
        end
    end

    assign bus.pc_out = r_pc;
    assign bus.sp     = r_sp;
    assign bus.full   = w_full;
    assign bus.empty  = w_empty;
    assign bus.fault  = (r_state == FAULT);
endmodule

// File: tb/tb_pc_seq.sv
// Bench for pc_seq: directed scenarios plus randomized traffic
// checked against a queue-based reference of the sequencer.
module tb_pc_seq;
    localparam int AW    = 16;
    localparam int DEPTH = 4;
    localparam int SPW   = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pc_seq_if #(.AW(AW), .DEPTH(DEPTH)) bus ();

    pc_seq #(
        .AW(AW),
        .DEPTH(DEPTH),
        .RST_VEC(16'h0000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic [AW-1:0] m_pc;
    logic [AW-1:0] m_stk [$];
    bit            m_fault;

    task automatic model_reset();
        m_pc = 16'h0000;
        m_stk.delete();
        m_fault = 1'b0;
    endtask

    task automatic model_step(input bit en, input bit jmp, input bit cmp,
                              input bit am, input bit call, input bit ret,
                              input logic [AW-1:0] rd);
        logic [AW-1:0] t;
        if (m_fault || !en) return;
        t = am ? rd : m_pc + rd;
        if (call && ret) begin
            m_fault = 1'b1;
        end else if (ret) begin
            if (m_stk.size() == 0) m_fault = 1'b1;
            else m_pc = m_stk.pop_back();
        end else if (call) begin
            if (m_stk.size() == DEPTH) begin
                m_fault = 1'b1;
            end else begin
                m_stk.push_back(m_pc + 16'd1);
                m_pc = t;
            end
        end else if (jmp && cmp) begin
            m_pc = t;
        end else begin
            m_pc = m_pc + 16'd1;
        end
    endtask

    task automatic set_inputs(input bit en, input bit jmp, input bit cmp,
                              input bit am, input bit call, input bit ret,
                              input logic [AW-1:0] rd);
        bus.en = en;
        bus.jmp = jmp;
        bus.cmp = cmp;
        bus.abs_mode = am;
        bus.call = call;
        bus.ret = ret;
        bus.rd = rd;
    endtask

    task automatic drive(input bit en, input bit jmp, input bit cmp,
                         input bit am, input bit call, input bit ret,
                         input logic [AW-1:0] rd);
        set_inputs(en, jmp, cmp, am, call, ret, rd);
        model_step(en, jmp, cmp, am, call, ret, rd);
        @(posedge clk);
        #1;
    endtask

    task automatic hw_reset();
        set_inputs(0, 0, 0, 0, 0, 0, 16'h0000);
        rst = 1'b0;
        model_reset();
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        set_inputs(0, 0, 0, 0, 0, 0, 16'h0000);
        rst = 1'b0;
        model_reset();
        #2;
        vectors++;
        if (bus.pc_out !== 16'h0000 || bus.sp !== 3'd0 ||
            bus.empty !== 1'b1 || bus.full !== 1'b0 || bus.fault !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_async pc=%h sp=%0d e=%b f=%b flt=%b exp 0000/0/1/0/0",
                     bus.pc_out, bus.sp, bus.empty, bus.full, bus.fault);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 1; i <= 3; i++) begin
            drive(1, 0, 0, 0, 0, 0, 16'h0000);
            vectors++;
            if (bus.pc_out !== 16'(i) || bus.sp !== 3'd0 || bus.empty !== 1'b1) begin
                miscompares++;
                $display("FAIL reset_incr%0d pc=%h sp=%0d e=%b exp pc=%h sp=0 e=1",
                         i, bus.pc_out, bus.sp, bus.empty, 16'(i));
            end
        end
        set_inputs(1, 0, 0, 1, 1, 0, 16'h0100);
        #1;
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        vectors++;
        if (bus.pc_out !== 16'h0000 || bus.sp !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_midcall pc=%h sp=%0d exp pc=0000 sp=0",
                     bus.pc_out, bus.sp);
        end
        set_inputs(0, 0, 0, 0, 0, 0, 16'h0000);
        #1;
        rst = 1'b1;
        #1;
        drive(1, 0, 0, 0, 0, 0, 16'h0000);
        vectors++;
        if (bus.pc_out !== 16'h0001 || bus.sp !== 3'd0 || bus.fault !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release pc=%h sp=%0d flt=%b exp pc=0001 sp=0 flt=0",
                     bus.pc_out, bus.sp, bus.fault);
        end
    endtask

    task automatic test_jump();
        drive(1, 1, 1, 1, 0, 0, 16'h0010);
        drive(1, 1, 1, 0, 0, 0, 16'hFFFC);
        vectors++;
        if (bus.pc_out !== 16'h000C) begin
            miscompares++;
            $display("FAIL jump_rel pc=%h exp 000C", bus.pc_out);
        end
        drive(1, 1, 1, 1, 0, 0, 16'h0010);
        drive(1, 1, 0, 0, 0, 0, 16'hFFFC);
        vectors++;
        if (bus.pc_out !== 16'h0011) begin
            miscompares++;
            $display("FAIL jump_nottaken pc=%h exp 0011", bus.pc_out);
        end
        drive(1, 1, 1, 1, 0, 0, 16'h1234);
        vectors++;
        if (bus.pc_out !== 16'h1234) begin
            miscompares++;
            $display("FAIL jump_abs pc=%h exp 1234", bus.pc_out);
        end
        drive(1, 0, 1, 1, 0, 0, 16'h7777);
        vectors++;
        if (bus.pc_out !== 16'h1235) begin
            miscompares++;
            $display("FAIL jump_nojmp pc=%h exp 1235", bus.pc_out);
        end
    endtask

    task automatic test_call_ret();
        drive(1, 1, 1, 1, 0, 0, 16'h0020);
        drive(1, 0, 0, 1, 1, 0, 16'h0100);
        vectors++;
        if (bus.pc_out !== 16'h0100 || bus.sp !== 3'd1 || bus.empty !== 1'b0) begin
            miscompares++;
            $display("FAIL call_abs pc=%h sp=%0d e=%b exp pc=0100 sp=1 e=0",
                     bus.pc_out, bus.sp, bus.empty);
        end
        drive(1, 0, 0, 0, 0, 0, 16'h0000);
        drive(1, 0, 0, 0, 0, 0, 16'h0000);
        drive(1, 1, 1, 1, 0, 1, 16'h5555);
        vectors++;
        if (bus.pc_out !== 16'h0021 || bus.sp !== 3'd0 || bus.empty !== 1'b1) begin
            miscompares++;
            $display("FAIL ret_basic pc=%h sp=%0d e=%b exp pc=0021 sp=0 e=1",
                     bus.pc_out, bus.sp, bus.empty);
        end
        drive(1, 0, 0, 0, 1, 0, 16'h0010);
        vectors++;
        if (bus.pc_out !== 16'h0031 || bus.sp !== 3'd1) begin
            miscompares++;
            $display("FAIL call_rel pc=%h sp=%0d exp pc=0031 sp=1",
                     bus.pc_out, bus.sp);
        end
        drive(1, 0, 0, 1, 1, 0, 16'h0400);
        drive(1, 0, 0, 1, 1, 0, 16'h0800);
        drive(1, 0, 0, 0, 0, 1, 16'h0000);
        drive(1, 0, 0, 0, 0, 1, 16'h0000);
        vectors++;
        if (bus.pc_out !== 16'h0032 || bus.sp !== 3'd1) begin
            miscompares++;
            $display("FAIL ret_lifo pc=%h sp=%0d exp pc=0032 sp=1",
                     bus.pc_out, bus.sp);
        end
        drive(1, 0, 0, 0, 0, 1, 16'h0000);
        vectors++;
        if (bus.pc_out !== 16'h0022 || bus.sp !== 3'd0) begin
            miscompares++;
            $display("FAIL ret_outer pc=%h sp=%0d exp pc=0022 sp=0",
                     bus.pc_out, bus.sp);
        end
    endtask

    task automatic test_overflow();
        hw_reset();
        for (int i = 1; i <= 4; i++) begin
            drive(1, 0, 0, 1, 1, 0, 16'(i * 256));
        end
        vectors++;
        if (bus.sp !== 3'd4 || bus.full !== 1'b1 || bus.pc_out !== 16'h0400) begin
            miscompares++;
            $display("FAIL ovf_fill sp=%0d full=%b pc=%h exp sp=4 full=1 pc=0400",
                     bus.sp, bus.full, bus.pc_out);
        end
        drive(1, 0, 0, 1, 1, 0, 16'h0500);
        vectors++;
        if (bus.fault !== 1'b1 || bus.pc_out !== 16'h0400 || bus.sp !== 3'd4) begin
            miscompares++;
            $display("FAIL ovf_fault flt=%b pc=%h sp=%0d exp flt=1 pc=0400 sp=4",
                     bus.fault, bus.pc_out, bus.sp);
        end
        for (int i = 0; i < 10; i++) begin
            drive(1, 1, 1, 1, (i % 3) == 1, (i % 3) == 2, 16'h0ABC);
            vectors++;
            if (bus.fault !== 1'b1 || bus.pc_out !== 16'h0400 || bus.sp !== 3'd4) begin
                miscompares++;
                $display("FAIL ovf_hold%0d flt=%b pc=%h sp=%0d exp flt=1 pc=0400 sp=4",
                         i, bus.fault, bus.pc_out, bus.sp);
            end
        end
        set_inputs(1, 0, 0, 0, 0, 0, 16'h0000);
        rst = 1'b0;
        model_reset();
        #2;
        vectors++;
        if (bus.pc_out !== 16'h0000 || bus.fault !== 1'b0 || bus.sp !== 3'd0) begin
            miscompares++;
            $display("FAIL ovf_reset pc=%h flt=%b sp=%0d exp pc=0000 flt=0 sp=0",
                     bus.pc_out, bus.fault, bus.sp);
        end
        set_inputs(0, 0, 0, 0, 0, 0, 16'h0000);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_underflow();
        hw_reset();
        drive(1, 0, 0, 0, 0, 1, 16'h0000);
        vectors++;
        if (bus.fault !== 1'b1 || bus.pc_out !== 16'h0000) begin
            miscompares++;
            $display("FAIL unf_fault flt=%b pc=%h exp flt=1 pc=0000",
                     bus.fault, bus.pc_out);
        end
        hw_reset();
        drive(1, 0, 0, 1, 1, 0, 16'h0040);
        drive(1, 1, 1, 1, 1, 1, 16'h0080);
        vectors++;
        if (bus.fault !== 1'b1 || bus.sp !== 3'd1 || bus.pc_out !== 16'h0040) begin
            miscompares++;
            $display("FAIL callret_fault flt=%b sp=%0d pc=%h exp flt=1 sp=1 pc=0040",
                     bus.fault, bus.sp, bus.pc_out);
        end
    endtask

    task automatic test_wrap_stall();
        hw_reset();
        drive(1, 1, 1, 1, 0, 0, 16'hFFFF);
        drive(1, 0, 0, 0, 0, 0, 16'h0000);
        vectors++;
        if (bus.pc_out !== 16'h0000 || bus.fault !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap pc=%h flt=%b exp pc=0000 flt=0",
                     bus.pc_out, bus.fault);
        end
        drive(1, 0, 0, 1, 1, 0, 16'h0300);
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 1, 1, 1, i == 4, 16'h0999);
            vectors++;
            if (bus.pc_out !== 16'h0300 || bus.sp !== 3'd1 || bus.fault !== 1'b0) begin
                miscompares++;
                $display("FAIL stall%0d pc=%h sp=%0d flt=%b exp pc=0300 sp=1 flt=0",
                         i, bus.pc_out, bus.sp, bus.fault);
            end
        end
    endtask

    task automatic test_random();
        hw_reset();
        for (int i = 0; i < 500; i++) begin
            if (m_fault && $urandom_range(0, 3) == 0) hw_reset();
            drive($urandom_range(0, 99) < 90, $urandom_range(0, 99) < 40,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 99) < 18, $urandom_range(0, 99) < 14,
                  16'($urandom));
            vectors++;
            if (bus.pc_out !== m_pc || bus.sp !== SPW'(m_stk.size()) ||
                bus.full !== (m_stk.size() == DEPTH) ||
                bus.empty !== (m_stk.size() == 0) || bus.fault !== m_fault) begin
                miscompares++;
                $display("FAIL random%0d pc=%h sp=%0d flt=%b exp pc=%h sp=%0d flt=%b",
                         i, bus.pc_out, bus.sp, bus.fault,
                         m_pc, m_stk.size(), m_fault);
            end
        end
    endtask

    initial begin
        set_inputs(0, 0, 0, 0, 0, 0, 16'h0000);
        #1;
        test_reset();
        test_jump();
        test_call_ret();
        test_overflow();
        test_underflow();
        test_wrap_stall();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
